sad_min_selector: RTL and testbench

Streaming minimum-SAD search stage that sits directly downstream of the SAD calculator in the motion-estimation datapath. It accepts one row of 16 candidate SADs (16-bit unsigned) per beat over 16 beats, covering a 16x16 search window. It reports the smallest SAD, its position, and the corresponding signed motion vector, and holds the result until the consumer accepts it.

---
 rtl/sad_min_selector.sv | 140 ++++++++++++++
 tb/tb_sad_min_selector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sad_min_selector.sv
// Streaming minimum-SAD search over a 16x16 window, one row per beat.
// Two registered stages (row reduce, running best) plus an accept/drain/done FSM.
module sad_min_selector #(
    parameter int N_COLS = 16,
    parameter int N_ROWS = 16,
    parameter int SAD_W  = 16,
    parameter int MV_OFS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_COLS*SAD_W-1:0]   in_sad_row,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [SAD_W-1:0]          out_sad,
    output logic [3:0]                out_row,
    output logic [3:0]                out_col,
    output logic [4:0]                out_mv_y,
    output logic [4:0]                out_mv_x,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_e;

    localparam logic [3:0] LAST_ROW = 4'(N_ROWS - 1);

    state_e           state_q;
    logic [3:0]       row_q;
    logic             out_valid_q;
    logic             accept;

    logic [SAD_W-1:0] row_min_d;
    logic [3:0]       row_col_d;

    logic             s1_valid_q;
    logic [SAD_W-1:0] s1_min_q;
    logic [3:0]       s1_col_q;
    logic [3:0]       s1_row_q;

    logic [SAD_W-1:0] best_sad_q;
    logic [3:0]       best_row_q;
    logic [3:0]       best_col_q;
    logic [4:0]       mv_y_q;
    logic [4:0]       mv_x_q;
    logic             take_best;

    // Gated by rst_n so nothing is accepted while reset is held.
    assign in_ready = rst_n && (state_q == ACCUM);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            row_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (row_q == LAST_ROW) begin
                            state_q <= DRAIN;
                            row_q   <= '0;
                        end else begin
                            row_q <= row_q + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Strict less-than scan from column 0 keeps the lowest column on ties.
    always_comb begin
        row_min_d = in_sad_row[SAD_W-1:0];
        row_col_d = '0;
        for (int c = 1; c < N_COLS; c++) begin
            if (in_sad_row[c*SAD_W +: SAD_W] < row_min_d) begin
                row_min_d = in_sad_row[c*SAD_W +: SAD_W];
                row_col_d = 4'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_min_q   <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_min_q <= row_min_d;
                s1_col_q <= row_col_d;
                s1_row_q <= row_q;
            end
        end
    end

    assign take_best = s1_valid_q &&
                       ((s1_row_q == 4'd0) || (s1_min_q < best_sad_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_sad_q <= '0;
            best_row_q <= '0;
            best_col_q <= '0;
            mv_y_q     <= '0;
            mv_x_q     <= '0;
        end else if (take_best) begin
            best_sad_q <= s1_min_q;
            best_row_q <= s1_row_q;
            best_col_q <= s1_col_q;
            mv_y_q     <= {1'b0, s1_row_q} - 5'(MV_OFS);
            mv_x_q     <= {1'b0, s1_col_q} - 5'(MV_OFS);
        end
    end

    assign out_sad   = best_sad_q;
    assign out_row   = best_row_q;
    assign out_col   = best_col_q;
    assign out_mv_y  = mv_y_q;
    assign out_mv_x  = mv_x_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sad_min_selector.sv
// Directed bench for sad_min_selector: hand-computed results per window.
module tb_sad_min_selector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] in_sad_row;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  out_sad;
    logic [3:0]   out_row;
    logic [3:0]   out_col;
    logic [4:0]   out_mv_y;
    logic [4:0]   out_mv_x;
    logic         out_valid;
    logic         out_ready;

    int n_cmp = 0;
    int n_err = 0;
    int beats;
    logic [15:0] win [16][16];

    always #5 clk = ~clk;

    sad_min_selector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sad_row (in_sad_row),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sad    (out_sad),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_mv_y   (out_mv_y),
        .out_mv_x   (out_mv_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                win[r][c] = v;
    endtask

    function automatic logic [255:0] pack_row(input int r);
        logic [255:0] v;
        for (int c = 0; c < 16; c++) v[c*16 +: 16] = win[r][c];
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends all 16 rows, optionally with a bubble between beats,
    // then checks DRAIN/DONE timing relative to the last accept.
    task automatic send_window(input bit bubbles);
        int wait_cnt;
        beats = 0;
        for (int r = 0; r < 16; r++) begin
            in_valid   = 1'b1;
            in_sad_row = pack_row(r);
            wait_cnt   = 0;
            while (!in_ready && wait_cnt < 50) begin
                tick();
                wait_cnt++;
            end
            if (wait_cnt >= 50) begin
                chk("accept_timeout", 32'(wait_cnt), 32'd0);
                in_valid = 1'b0;
                return;
            end
            tick();
            beats++;
            if (bubbles && r != 15) begin
                in_valid   = 1'b0;
                in_sad_row = {8{$urandom()}};
                tick();
            end
        end
        in_valid = 1'b0;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("done_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic chk_result(input string tag, input logic [15:0] sad,
                              input logic [3:0] row, input logic [3:0] col,
                              input logic [4:0] mvy, input logic [4:0] mvx);
        chk({tag, "_sad"}, 32'(out_sad), 32'(sad));
        chk({tag, "_row"}, 32'(out_row), 32'(row));
        chk({tag, "_col"}, 32'(out_col), 32'(col));
        chk({tag, "_mvy"}, 32'(out_mv_y), 32'(mvy));
        chk({tag, "_mvx"}, 32'(out_mv_x), 32'(mvx));
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_sad_row = '0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_result("rst", 16'h0, 4'd0, 4'd0, 5'h00, 5'h00);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Unique minimum at (5,11)
        fill(16'h0100);
        win[5][11] = 16'h0003;
        send_window(1'b0);
        chk_result("uniq", 16'h0003, 4'd5, 4'd11, 5'h1D, 5'h03);
        handshake();

        // Ties: lowest row, then lowest column
        fill(16'h0020);
        win[2][9] = 16'h0010;
        win[2][4] = 16'h0010;
        win[7][0] = 16'h0010;
        send_window(1'b0);
        chk_result("tie", 16'h0010, 4'd2, 4'd4, 5'h1A, 5'h1C);
        handshake();

        // All 0xFFFF: row 0 must load unconditionally
        fill(16'hFFFF);
        send_window(1'b0);
        chk_result("ffff", 16'hFFFF, 4'd0, 4'd0, 5'h18, 5'h18);
        handshake();

        // Backpressure with the next window presented early
        fill(16'h0200);
        win[3][7] = 16'h0005;
        send_window(1'b0);
        fill(16'h0300);
        win[9][2] = 16'h0007;
        in_valid   = 1'b1;
        in_sad_row = pack_row(0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk_result("bp_hold", 16'h0005, 4'd3, 4'd7, 5'h1B, 5'h1F);
        end
        handshake();
        send_window(1'b0);
        chk_result("bp_next", 16'h0007, 4'd9, 4'd2, 5'h01, 5'h1A);
        handshake();

        // Bubbles between beats, minimum at (15,15)
        fill(16'h1234);
        win[15][15] = 16'h0000;
        send_window(1'b1);
        chk("bub_beats", 32'(beats), 32'd16);
        chk_result("bub", 16'h0000, 4'd15, 4'd15, 5'h07, 5'h07);
        handshake();

        // Reset after 7 beats; the partial window holds a smaller value
        fill(16'h0040);
        win[3][6] = 16'h0000;
        for (int r = 0; r < 7; r++) begin
            in_valid   = 1'b1;
            in_sad_row = pack_row(r);
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_rel_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_rel_out_valid", 32'(out_valid), 32'd0);
        fill(16'h0050);
        win[0][0] = 16'h0001;
        send_window(1'b0);
        chk_result("mrst", 16'h0001, 4'd0, 4'd0, 5'h18, 5'h18);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
